// File: rtl/simple_proc_ctrl.sv
// rtl/simple_proc_ctrl.sv - three-state single-issue sequencer with 8x16 register file and condition-code evaluation
module simple_proc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [23:0] instr,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_operand_1,
    output logic [15:0] alu_operand_2,
    output logic [6:0]  alu_imm,
    output logic        alu_cond_success,
    input  logic [15:0] alu_result,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        retire_valid,
    output logic        retire_executed,
    output logic [15:0] retire_data,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t      state;
    state_t      state_next;
    logic [23:0] ir;
    logic        cond_ok;
    logic [15:0] rf [8];
    logic        cond_pass;
    logic        rf_we;

    logic [3:0] ir_cond;
    logic [3:0] ir_op;
    logic [2:0] ir_rd;
    logic [2:0] ir_rn;
    logic [2:0] ir_rm;
    logic       op_writes;

    assign ir_cond = ir[23:20];
    assign ir_op   = ir[19:16];
    assign ir_rd   = ir[15:13];
    assign ir_rn   = ir[12:10];
    assign ir_rm   = ir[9:7];

    // CMP (1011) and 1101..1111 only affect flags or do nothing
    assign op_writes = (ir_op <= 4'd10) || (ir_op == 4'd12);

    assign alu_operand_1 = rf[ir_rn];
    assign alu_operand_2 = rf[ir_rm];
    assign alu_imm       = ir[6:0];
    assign dbg_data      = rf[dbg_addr];

    always_comb begin
        cond_pass = 1'b0;
        case (ir_cond)
            4'h0: cond_pass = alu_z;
            4'h1: cond_pass = !alu_z;
            4'h2: cond_pass = alu_c;
            4'h3: cond_pass = !alu_c;
            4'h4: cond_pass = alu_n;
            4'h5: cond_pass = !alu_n;
            4'h6: cond_pass = alu_v;
            4'h7: cond_pass = !alu_v;
            4'h8: cond_pass = alu_c && !alu_z;
            4'h9: cond_pass = !alu_c || alu_z;
            4'hA: cond_pass = (alu_n == alu_v);
            4'hB: cond_pass = (alu_n != alu_v);
            4'hC: cond_pass = !alu_z && (alu_n == alu_v);
            4'hD: cond_pass = alu_z || (alu_n != alu_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_next       = state;
        instr_ready      = 1'b0;
        alu_opcode       = 4'hF;
        alu_cond_success = 1'b0;
        retire_valid     = 1'b0;
        retire_executed  = 1'b0;
        retire_data      = 16'h0000;
        rf_we            = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = EXEC;
            end
            EXEC: begin
                alu_opcode       = ir_op;
                alu_cond_success = cond_pass;
                state_next       = WB;
            end
            WB: begin
                rf_we           = cond_ok && op_writes;
                retire_valid    = 1'b1;
                retire_executed = cond_ok;
                retire_data     = rf_we ? alu_result : 16'h0000;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= 24'h000000;
            cond_ok <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && instr_valid) ir <= instr;
            if (state == EXEC) cond_ok <= cond_pass;
        end
    end

    // Reset clears the whole file so an interrupted write never lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (rf_we) begin
            rf[ir_rd] <= alu_result;
        end
    end

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// tb/tb_simple_proc_ctrl.sv - self-checking bench for simple_proc_ctrl with a registered ALU model
module tb_simple_proc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [23:0] instr = 24'h0;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_operand_1;
    logic [15:0] alu_operand_2;
    logic [6:0]  alu_imm;
    logic        alu_cond_success;
    logic [15:0] alu_result = 16'h0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic        alu_c = 1'b0;
    logic        alu_v = 1'b0;
    logic        retire_valid;
    logic        retire_executed;
    logic [15:0] retire_data;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    simple_proc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_opcode(alu_opcode), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_imm(alu_imm), .alu_cond_success(alu_cond_success), .alu_result(alu_result),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .retire_valid(retire_valid), .retire_executed(retire_executed), .retire_data(retire_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } alu_out_t;

    // Environment ALU: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 ADDI,6 SUBI,7 SHL,8 SHR,9 NOT,10 MOV,11 CMP,12 MOVI
    function automatic alu_out_t alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic [6:0] imm);
        alu_out_t o;
        int unsigned x;
        int unsigned y;
        int unsigned s;
        o = '0;
        x = a;
        y = (op == 4'd5 || op == 4'd6) ? {25'd0, imm} : b;
        case (op)
            4'd0, 4'd5: begin
                s = x + y;
                o.res = s[15:0];
                o.c = (s > 65535);
                o.v = (a[15] == y[15]) && (o.res[15] != a[15]);
            end
            4'd1, 4'd6, 4'd11: begin
                s = x - y;
                o.res = s[15:0];
                o.c = (x >= y);
                o.v = (a[15] != y[15]) && (o.res[15] != a[15]);
            end
            4'd2:  o.res = a & b;
            4'd3:  o.res = a | b;
            4'd4:  o.res = a ^ b;
            4'd7:  o.res = a << 1;
            4'd8:  o.res = a >> 1;
            4'd9:  o.res = ~a;
            4'd10: o.res = b;
            4'd12: o.res = {9'd0, imm};
            default: o.res = 16'h0;
        endcase
        o.n = o.res[15];
        o.z = (o.res == 16'h0);
        return o;
    endfunction

    logic     frc_en = 1'b0;
    logic [3:0] frc_val = 4'h0;
    alu_out_t alu_next;

    always_comb alu_next = alu_calc(alu_opcode, alu_operand_1, alu_operand_2, alu_imm);

    always @(posedge clk) begin
        if (frc_en) begin
            {alu_n, alu_z, alu_c, alu_v} <= frc_val;
        end else if (alu_opcode != 4'hF) begin
            alu_result <= alu_next.res;
            if (alu_cond_success && alu_opcode <= 4'd12)
                {alu_n, alu_z, alu_c, alu_v} <= {alu_next.n, alu_next.z, alu_next.c, alu_next.v};
        end
    end

    logic [15:0] mrf [8];
    logic [3:0]  mflags = 4'h0;

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic [15:0] t;
        {n, z, c, v} = nzcv;
        t = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
             ~v, v, ~n, n, ~c, c, ~z, z};
        return t[cond];
    endfunction

    function automatic logic [23:0] mk(input logic [3:0] c, input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rn, input logic [2:0] rm, input logic [6:0] imm);
        return {c, op, rd, rn, rm, imm};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [23:0] ins, output logic p, output logic [15:0] d,
                              output logic [15:0] a, output logic [15:0] b);
        alu_out_t o;
        logic [3:0] op;
        logic wr;
        op = ins[19:16];
        a = mrf[ins[12:10]];
        b = mrf[ins[9:7]];
        p = cond_holds(ins[23:20], mflags);
        o = alu_calc(op, a, b, ins[6:0]);
        wr = p && (op <= 4'd10 || op == 4'd12);
        d = wr ? o.res : 16'h0;
        if (wr) mrf[ins[15:13]] = o.res;
        if (p && op <= 4'd12) mflags = {o.n, o.z, o.c, o.v};
    endtask

    task automatic force_flags(input logic [3:0] nzcv);
        @(negedge clk);
        frc_en = 1'b1;
        frc_val = nzcv;
        @(posedge clk);
        #1 frc_en = 1'b0;
        mflags = nzcv;
    endtask

    task automatic do_instr(input logic [23:0] ins, input bit use_tab, input logic t_pass, input logic [15:0] t_data);
        logic p, ep;
        logic [15:0] d, a, b, ed;
        int waited;
        waited = 0;
        model_step(ins, p, d, a, b);
        ep = use_tab ? t_pass : p;
        ed = use_tab ? t_data : d;
        @(negedge clk);
        while (!instr_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 64'(instr_ready), 64'd1);
            return;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("exec", {instr_ready, alu_opcode, alu_cond_success, alu_operand_1, alu_operand_2, alu_imm},
              {1'b0, ins[19:16], ep, a, b, ins[6:0]});
        @(negedge clk);
        check("retire", {instr_ready, retire_valid, retire_executed, retire_data}, {1'b0, 1'b1, ep, ed});
    endtask

    task automatic check_rf(input string name, input logic [15:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 check(name, 64'(dbg_data), 64'(exp[i]));
        end
    endtask

    typedef struct {
        bit          fe;
        logic [3:0]  nzcv;
        logic [23:0] ins;
        logic        pass;
        logic [15:0] data;
    } vec_t;

    vec_t tab [12];
    logic [15:0] zero_rf [8] = '{default: 16'h0};
    logic [15:0] final_rf [8] = '{16'd0, 16'd6, 16'd4, 16'd17, 16'd4, 16'd7, 16'd6, 16'd0};

    initial begin
        logic p;
        logic [15:0] d, a, b;

        tab[0]  = '{1'b1, 4'b0000, mk(4'hE, 4'd12, 3'd1, 3'd0, 3'd0, 7'd3),  1'b1, 16'd3};
        tab[1]  = '{1'b0, 4'b0000, mk(4'hE, 4'd12, 3'd2, 3'd0, 3'd0, 7'd4),  1'b1, 16'd4};
        tab[2]  = '{1'b0, 4'b0000, mk(4'hE, 4'd0,  3'd5, 3'd1, 3'd2, 7'd0),  1'b1, 16'd7};
        tab[3]  = '{1'b1, 4'b0100, mk(4'h1, 4'd0,  3'd5, 3'd1, 3'd2, 7'd0),  1'b0, 16'd0};
        tab[4]  = '{1'b0, 4'b0000, mk(4'hE, 4'd11, 3'd2, 3'd1, 3'd2, 7'd0),  1'b1, 16'd0};
        tab[5]  = '{1'b1, 4'b1001, mk(4'hA, 4'd0,  3'd6, 3'd1, 3'd1, 7'd0),  1'b1, 16'd6};
        tab[6]  = '{1'b0, 4'b0000, mk(4'hF, 4'd12, 3'd7, 3'd0, 3'd0, 7'h55), 1'b0, 16'd0};
        tab[7]  = '{1'b1, 4'b0000, mk(4'h9, 4'd5,  3'd3, 3'd5, 3'd0, 7'd10), 1'b1, 16'd17};
        tab[8]  = '{1'b1, 4'b0010, mk(4'h8, 4'd1,  3'd4, 3'd5, 3'd1, 7'd0),  1'b1, 16'd4};
        tab[9]  = '{1'b1, 4'b0001, mk(4'hC, 4'd12, 3'd4, 3'd0, 3'd0, 7'd9),  1'b0, 16'd0};
        tab[10] = '{1'b0, 4'b0000, mk(4'hE, 4'd0,  3'd1, 3'd1, 3'd1, 7'd0),  1'b1, 16'd6};
        tab[11] = '{1'b0, 4'b0000, mk(4'hE, 4'd13, 3'd2, 3'd0, 3'd0, 7'd0),  1'b1, 16'd0};

        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ctrl", {instr_ready, retire_valid, retire_executed, retire_data, alu_opcode, alu_cond_success},
              {1'b1, 1'b0, 1'b0, 16'h0, 4'hF, 1'b0});
        check_rf("reset_rf", zero_rf);

        for (int i = 0; i < 12; i++) begin
            if (tab[i].fe) force_flags(tab[i].nzcv);
            do_instr(tab[i].ins, 1'b1, tab[i].pass, tab[i].data);
        end
        @(negedge clk);
        check_rf("table_rf", final_rf);

        // Back-to-back with instr_valid held high
        @(negedge clk);
        model_step(mk(4'hE, 4'd12, 3'd0, 3'd0, 3'd0, 7'h2A), p, d, a, b);
        model_step(mk(4'hE, 4'd0, 3'd1, 3'd0, 3'd0, 7'd0), p, d, a, b);
        instr = mk(4'hE, 4'd12, 3'd0, 3'd0, 3'd0, 7'h2A);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr = mk(4'hE, 4'd0, 3'd1, 3'd0, 3'd0, 7'd0);
        @(negedge clk);
        check("b2b_cyc1_ready", 64'(instr_ready), 64'd0);
        @(negedge clk);
        check("b2b_cyc2", {instr_ready, retire_valid, retire_data}, {1'b0, 1'b1, 16'h002A});
        @(negedge clk);
        check("b2b_cyc3_ready", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_operand", 64'(alu_operand_1), 64'h2A);
        @(negedge clk);
        check("b2b_second_retire", {retire_valid, retire_data}, {1'b1, 16'h0054});

        // Reset asserted while a write to R3 is in EXEC
        @(negedge clk);
        instr = mk(4'hE, 4'd12, 3'd3, 3'd0, 3'd0, 7'h11);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_exec_imm", {instr_ready, retire_valid, alu_opcode}, {1'b1, 1'b0, 4'hF});
        repeat (2) begin
            @(negedge clk);
            check("rst_exec_noretire", 64'(retire_valid), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
        check_rf("rst_exec_rf", zero_rf);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2) == 0) force_flags(4'($urandom_range(15)));
            do_instr(24'($urandom), 1'b0, 1'b0, 16'h0);
        end
        @(negedge clk);
        check_rf("random_rf", mrf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
